// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle RISC-V control FSM with PC/IR ownership and retire counter
// Optional feature: MULTICYCLE_STEP_EN adds a step input and a STEP_WAIT state after each retire.
module multicycle_sequencer #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        zero,
  input  logic [63:0] branch_target,
  input  logic        mem_ready,
`ifdef MULTICYCLE_STEP_EN
  input  logic        step,
`endif
  output logic [63:0] pc,
  output logic [31:0] ir,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic [1:0]  alu_op,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic        mem_error,
  output logic [31:0] instret
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;
  localparam logic [2:0] S_STEP_WAIT = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  // Where a retiring instruction goes next: single-step mode parks in STEP_WAIT.
`ifdef MULTICYCLE_STEP_EN
  localparam logic [2:0] S_RETIRE = S_STEP_WAIT;
`else
  localparam logic [2:0] S_RETIRE = S_FETCH;
`endif

  logic [2:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] instret_q, instret_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        illegal_q, illegal_d;
  logic        mem_error_q, mem_error_d;

  logic [6:0]  opcode;
  logic        is_r, is_i, is_ld, is_st, is_br;
  logic [63:0] pc_plus4;

  assign opcode   = ir_q[6:0];
  assign is_r     = (opcode == OP_R);
  assign is_i     = (opcode == OP_I);
  assign is_ld    = (opcode == OP_LOAD);
  assign is_st    = (opcode == OP_STORE);
  assign is_br    = (opcode == OP_BRANCH);
  assign pc_plus4 = pc_q + 64'd4;

  // State register and architectural state, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= 32'h0;
      instret_q   <= 32'h0;
      cnt_q       <= 8'h0;
      illegal_q   <= 1'b0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      instret_q   <= instret_d;
      cnt_q       <= cnt_d;
      illegal_q   <= illegal_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Next-state logic: sequencing, PC update, retire counting and memory timeout.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    instret_d   = instret_q;
    cnt_d       = cnt_q;
    illegal_d   = illegal_q;
    mem_error_d = mem_error_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_r || is_i || is_ld || is_st || is_br) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_HALT;
          // ECALL/EBREAK halt cleanly; any other opcode is flagged.
          if (opcode != OP_SYSTEM) illegal_d = 1'b1;
        end
      end
      S_EXECUTE: begin
        if (is_br) begin
          pc_d      = zero ? branch_target : pc_plus4;
          instret_d = instret_q + 32'd1;
          state_d   = S_RETIRE;
        end else if (is_ld || is_st) begin
          cnt_d   = 8'h0;
          state_d = S_MEMORY;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        // A ready on the timeout cycle still completes the access.
        if (mem_ready) begin
          if (is_st) begin
            pc_d      = pc_plus4;
            instret_d = instret_q + 32'd1;
            state_d   = S_RETIRE;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (cnt_q == TIMEOUT) begin
          mem_error_d = 1'b1;
          state_d     = S_HALT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WRITEBACK: begin
        pc_d      = pc_plus4;
        instret_d = instret_q + 32'd1;
        state_d   = S_RETIRE;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      S_STEP_WAIT: begin
`ifdef MULTICYCLE_STEP_EN
        if (step) state_d = S_FETCH;
`else
        state_d = S_FETCH;
`endif
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  // Output decode: datapath controls asserted only in their owning state.
  always_comb begin
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = 2'b00;
    case (state_q)
      S_EXECUTE: begin
        if (is_r) begin
          alu_op  = 2'b10;
          alu_src = 1'b0;
        end else if (is_i) begin
          alu_op  = 2'b10;
          alu_src = 1'b1;
        end else if (is_ld || is_st) begin
          alu_op  = 2'b00;
          alu_src = 1'b1;
        end else if (is_br) begin
          alu_op  = 2'b01;
          alu_src = 1'b0;
        end
      end
      S_MEMORY: begin
        mem_read  = is_ld;
        mem_write = is_st;
      end
      S_WRITEBACK: begin
        reg_write  = 1'b1;
        mem_to_reg = is_ld;
      end
      default: begin
        reg_write = 1'b0;
      end
    endcase
  end

  assign pc        = pc_q;
  assign ir        = ir_q;
  assign state     = state_q;
  assign halted    = (state_q == S_HALT);
  assign illegal   = illegal_q;
  assign mem_error = mem_error_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed self-checking bench for multicycle_sequencer
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        zero;
  logic [63:0] branch_target;
  logic        mem_ready;
`ifdef MULTICYCLE_STEP_EN
  logic        step;
`endif
  logic [63:0] pc;
  logic [31:0] ir;
  logic        reg_write, mem_read, mem_write, alu_src, mem_to_reg;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic        halted, illegal, mem_error;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  int rd_cnt;
  logic seen6 = 1'b0;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_BEQ   = 32'h00000063;
  localparam logic [31:0] I_LD    = 32'h0000B183;
  localparam logic [31:0] I_SD    = 32'h0020B023;
  localparam logic [31:0] I_BAD   = 32'h0000007F;
  localparam logic [31:0] I_ECALL = 32'h00000073;

  multicycle_sequencer #(.RESET_PC(64'h100), .MEM_TIMEOUT(15)) dut (
    .clk(clk),
    .reset(reset),
    .instruction(instruction),
    .zero(zero),
    .branch_target(branch_target),
    .mem_ready(mem_ready),
`ifdef MULTICYCLE_STEP_EN
    .step(step),
`endif
    .pc(pc),
    .ir(ir),
    .reg_write(reg_write),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .alu_src(alu_src),
    .mem_to_reg(mem_to_reg),
    .alu_op(alu_op),
    .state(state),
    .halted(halted),
    .illegal(illegal),
    .mem_error(mem_error),
    .instret(instret)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (state == 3'd6) seen6 <= 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    instruction = I_BEQ;
    zero = 1'b1;
    branch_target = 64'h200;
    mem_ready = 1'b0;
`ifdef MULTICYCLE_STEP_EN
    step = 1'b0;
`endif
    tick(2);
    check("rst_pc", pc, 64'h100);
    check("rst_state", 64'(state), 64'd0);
    check("rst_instret", 64'(instret), 64'd0);
    check("rst_ir", 64'(ir), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_enables", 64'({reg_write, mem_read, mem_write, mem_to_reg}), 64'd0);

    // Reset in EXECUTE aborts the branch.
    reset = 1'b0;
    tick(2);
    check("exec_state", 64'(state), 64'd2);
    check("exec_beq_aluop", 64'(alu_op), 64'd1);
    reset = 1'b1;
    tick(1);
    check("abort_state", 64'(state), 64'd0);
    check("abort_instret", 64'(instret), 64'd0);
    check("abort_pc", pc, 64'h100);

    // add x3,x1,x2: four edges, reg_write only in WRITEBACK.
    reset = 1'b0;
    instruction = I_ADD;
    tick(1);
    check("add_c1_state", 64'(state), 64'd1);
    check("add_c1_ir", 64'(ir), 64'(I_ADD));
    check("add_c1_rw", 64'(reg_write), 64'd0);
    tick(1);
    check("add_c2_aluop", 64'({alu_op, alu_src}), 64'b100);
    check("add_c2_rw", 64'(reg_write), 64'd0);
    tick(1);
    check("add_c3_state", 64'(state), 64'd4);
    check("add_c3_rw", 64'(reg_write), 64'd1);
    check("add_c3_pc", pc, 64'h100);
    tick(1);
    check("add_pc", pc, 64'h104);
    check("add_instret", 64'(instret), 64'd1);
    check("add_rw_off", 64'(reg_write), 64'd0);

    // beq taken, then not taken.
    instruction = I_BEQ;
    zero = 1'b1;
    tick(3);
    check("beq_t_pc", pc, 64'h200);
    check("beq_t_state", 64'(state), 64'd0);
    check("beq_t_instret", 64'(instret), 64'd2);
    zero = 1'b0;
    tick(3);
    check("beq_nt_pc", pc, 64'h204);
    check("beq_nt_instret", 64'(instret), 64'd3);

    // Load with three not-ready cycles: eight edges, mem_read high four cycles.
    instruction = I_LD;
    mem_ready = 1'b0;
    rd_cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (mem_read) rd_cnt++;
      mem_ready = (rd_cnt == 4) && mem_read;
      if (i == 2) check("ld_aluop", 64'({alu_op, alu_src}), 64'b001);
      if (i == 7) begin
        check("ld_wb_ctl", 64'({reg_write, mem_to_reg}), 64'b11);
        check("ld_wb_instret", 64'(instret), 64'd3);
      end
    end
    mem_ready = 1'b0;
    check("ld_rd_cycles", 64'(rd_cnt), 64'd4);
    check("ld_state", 64'(state), 64'd0);
    check("ld_instret", 64'(instret), 64'd4);
    check("ld_pc", pc, 64'h208);

    // Store timing out: sixteen MEMORY cycles, then HALT with mem_error.
    instruction = I_SD;
    tick(18);
    check("st_to_state_pre", 64'(state), 64'd3);
    check("st_to_memwrite", 64'(mem_write), 64'd1);
    check("st_to_err_pre", 64'(mem_error), 64'd0);
    tick(1);
    check("st_to_state", 64'(state), 64'd5);
    check("st_to_err", 64'(mem_error), 64'd1);
    check("st_to_halted", 64'(halted), 64'd1);
    check("st_to_instret", 64'(instret), 64'd4);
    check("st_to_pc", pc, 64'h208);
    check("st_to_memwrite_off", 64'(mem_write), 64'd0);

    // Store whose ready arrives on the timeout cycle completes.
    reset = 1'b1;
    tick(1);
    check("rst2_err", 64'(mem_error), 64'd0);
    reset = 1'b0;
    tick(18);
    mem_ready = 1'b1;
    tick(1);
    mem_ready = 1'b0;
    check("st_rw_state", 64'(state), 64'd0);
    check("st_rw_err", 64'(mem_error), 64'd0);
    check("st_rw_instret", 64'(instret), 64'd1);
    check("st_rw_pc", pc, 64'h104);

    // Illegal opcode halts and freezes.
    instruction = I_BAD;
    tick(2);
    check("ill_state", 64'(state), 64'd5);
    check("ill_flag", 64'(illegal), 64'd1);
    instruction = I_ADD;
    tick(20);
    check("ill_pc_frozen", pc, 64'h104);
    check("ill_ir_frozen", 64'(ir), 64'(I_BAD));
    check("ill_halted", 64'(halted), 64'd1);
    check("ill_instret", 64'(instret), 64'd1);

    // ECALL halts without flagging illegal.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    instruction = I_ECALL;
    tick(2);
    check("ecall_halted", 64'(halted), 64'd1);
    check("ecall_illegal", 64'(illegal), 64'd0);
    tick(20);
    check("ecall_pc_frozen", pc, 64'h100);
    check("ecall_state", 64'(state), 64'd5);

`ifdef MULTICYCLE_STEP_EN
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    instruction = I_ADD;
    tick(4);
    check("step_wait", 64'(state), 64'd6);
    tick(3);
    check("step_hold", 64'(state), 64'd6);
    step = 1'b1;
    tick(1);
    step = 1'b0;
    check("step_fetch", 64'(state), 64'd0);
`else
    check("no_step_wait", 64'(seen6), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
